// File: rtl/mono_framebuffer_scanout.sv
// Mono framebuffer: stores 16-pixel 1bpp words and scans them out as serial video with hsync/vsync.
// Define MONO_DOUBLE_BUFFER_EN for a two-bank framebuffer swapped on in_vsync at frame boundaries.
module mono_framebuffer_scanout #(
  parameter int unsigned WIDTH        = 512,
  parameter int unsigned HEIGHT       = 342,
  parameter int unsigned H_TOTAL      = 704,
  parameter int unsigned H_SYNC_START = 528,
  parameter int unsigned H_SYNC_LEN   = 128,
  parameter int unsigned V_TOTAL      = 370,
  parameter int unsigned V_SYNC_START = 342,
  parameter int unsigned V_SYNC_LEN   = 4,
  parameter bit          INVERT       = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] bits,
  input  logic [11:0] xaddr,
  input  logic [11:0] yaddr,
  input  logic        bits_ready,
  input  logic        in_vsync,
  output logic        video,
  output logic        hsync,
  output logic        vsync
);

  localparam int unsigned WORDS      = WIDTH / 16;
  localparam int unsigned BANK_WORDS = WORDS * HEIGHT;
  localparam int unsigned AW         = $clog2(BANK_WORDS);
  localparam int unsigned HW         = $clog2(H_TOTAL);
  localparam int unsigned VW         = $clog2(V_TOTAL);
`ifdef MONO_DOUBLE_BUFFER_EN
  localparam int unsigned RAW   = AW + 1;
  localparam int unsigned DEPTH = 2 ** RAW;
`else
  localparam int unsigned RAW   = AW;
  localparam int unsigned DEPTH = BANK_WORDS;
`endif

  logic [HW-1:0]  h_count;
  logic [VW-1:0]  v_count;
  logic [31:0]    h32, v32, nx, nl;
  logic           h_last, v_last;
  logic           wr_ok, rd_en, rd_valid;
  logic [AW-1:0]  wr_addr, rd_addr;
  logic [RAW-1:0] wr_full, rd_full;
  logic [15:0]    mem [DEPTH];
  logic [15:0]    ram_q, prefetch, shift, shift_cur;
  logic           pixel, active, hs_on, vs_on;

  always_comb begin
    h32    = 32'(h_count);
    v32    = 32'(v_count);
    h_last = (h32 == H_TOTAL - 1);
    v_last = (v32 == V_TOTAL - 1);
    // Word displayed from h_count+2; past the line end it is word 0 of the next line
    nx = h32 + 32'd2;
    nl = v32;
    if (nx >= H_TOTAL) begin
      nx = '0;
      nl = v_last ? '0 : v32 + 32'd1;
    end
    rd_en   = (h_count[3:0] == 4'd14) && (nx < WIDTH) && (nl < HEIGHT);
    rd_addr = AW'(nl * WORDS + (nx >> 4));
    wr_ok   = bits_ready && reset_n && (32'(xaddr) < WIDTH) && (32'(yaddr) < HEIGHT);
    wr_addr = AW'(32'(yaddr) * WORDS + 32'(xaddr[11:4]));
    shift_cur = (h_count[3:0] == 4'd0) ? prefetch : shift;
    pixel   = shift_cur[15];
    active  = (h32 < WIDTH) && (v32 < HEIGHT);
    hs_on   = (h32 >= H_SYNC_START) && (h32 < H_SYNC_START + H_SYNC_LEN);
    vs_on   = (v32 >= V_SYNC_START) && (v32 < V_SYNC_START + V_SYNC_LEN);
  end

`ifdef MONO_DOUBLE_BUFFER_EN
  logic wr_bank, rd_bank, pending, rd_bank_next, rd_bank_eff, swap;

  always_comb begin
    swap         = h_last && v_last;
    rd_bank_next = pending ? !wr_bank : rd_bank;
    // The prefetch for the first word of a new frame must already use the bank chosen at the swap
    rd_bank_eff  = ((h32 + 32'd2 >= H_TOTAL) && v_last) ? rd_bank_next : rd_bank;
    wr_full      = {wr_bank, wr_addr};
    rd_full      = {rd_bank_eff, rd_addr};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (in_vsync) wr_bank <= !wr_bank;
      if (swap) rd_bank <= rd_bank_next;
      pending <= in_vsync || (pending && !swap);
    end
  end
`else
  logic unused_vsync;
  assign unused_vsync = in_vsync;

  always_comb begin
    wr_full = wr_addr;
    rd_full = rd_addr;
  end
`endif

  // Plain RAM: not reset, read returns the old word on a same-address write
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_full] <= bits;
    if (rd_en) ram_q <= mem[rd_full];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_count  <= '0;
      v_count  <= '0;
      rd_valid <= 1'b0;
      prefetch <= '0;
      shift    <= '0;
      video    <= INVERT;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
    end else begin
      if (h_last) begin
        h_count <= '0;
        v_count <= v_last ? '0 : v_count + VW'(1);
      end else begin
        h_count <= h_count + HW'(1);
      end
      rd_valid <= rd_en;
      if (h_count[3:0] == 4'd15) prefetch <= rd_valid ? ram_q : '0;
      shift <= {shift_cur[14:0], 1'b0};
      video <= active ? (pixel ^ INVERT) : INVERT;
      hsync <= !hs_on;
      vsync <= !vs_on;
    end
  end

endmodule

// File: tb/tb_mono_framebuffer_scanout.sv
// Self-checking bench for mono_framebuffer_scanout on a reduced raster; honours MONO_DOUBLE_BUFFER_EN.
module tb_mono_framebuffer_scanout;
  localparam int unsigned W = 64, H = 10, HT = 96, HSS = 70, HSL = 8;
  localparam int unsigned VT = 14, VSS = 11, VSL = 2;
  localparam bit          INV = 1'b1;
  localparam int unsigned WD = W / 16, FRAME = HT * VT;

  logic clk, reset_n, bits_ready, in_vsync, video, hsync, vsync;
  logic [15:0] bits;
  logic [11:0] xaddr, yaddr;

  mono_framebuffer_scanout #(
    .WIDTH(W), .HEIGHT(H), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
    .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL), .INVERT(INV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bits(bits), .xaddr(xaddr), .yaddr(yaddr),
    .bits_ready(bits_ready), .in_vsync(in_vsync), .video(video), .hsync(hsync), .vsync(vsync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bits;
    logic [11:0] x;
    logic [11:0] y;
    bit          vs;
  } op_t;

  op_t         wq[$];
  logic [15:0] fb [2][H][WD];
  int unsigned mdl_wr, mdl_rd, cyc, col_frame, col_bank;
  bit          pend, col_arm, col_apply, gap;
  logic [15:0] col_data;
  logic [HT-1:0] ov, ev, oh, eh, ovs, evs;
  int unsigned vectors, miscompares;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_line(input string tag, input logic [HT-1:0] obs, input logic [HT-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input op_t o);
    if (o.vs) begin
      in_vsync = 1'b1;
`ifdef MONO_DOUBLE_BUFFER_EN
      mdl_wr = 1 - mdl_wr;
      pend = 1'b1;
`endif
    end else begin
      bits_ready = 1'b1;
      bits  = o.bits;
      xaddr = o.x;
      yaddr = o.y;
      if (o.x < W && o.y < H) fb[mdl_wr][o.y][o.x >> 4] = o.bits;
    end
  endtask

  task automatic push_wr(input logic [15:0] b, input logic [11:0] x, input logic [11:0] y);
    op_t o;
    o.bits = b; o.x = x; o.y = y; o.vs = 1'b0;
    wq.push_back(o);
  endtask

  task automatic push_vs();
    op_t o;
    o.bits = '0; o.x = '0; o.y = '0; o.vs = 1'b1;
    wq.push_back(o);
  endtask

  // Expected outputs follow the counters by one clock; the first word after reset shows blank
  task automatic run_cycles(input int unsigned n);
    int unsigned t, ht, vt, hn, vn;
    logic [15:0] w;
    logic        pix;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      bits_ready = 1'b0;
      in_vsync   = 1'b0;
      t  = cyc - 1;
      ht = t % HT;
      vt = (t / HT) % VT;
      pix = 1'b0;
      if (ht < W && vt < H && t >= 16) begin
        w   = fb[mdl_rd][vt][ht / 16];
        pix = w[15 - (ht % 16)];
      end
      ev[ht]  = (ht < W && vt < H) ? (pix ^ INV) : INV;
      eh[ht]  = !(ht >= HSS && ht < HSS + HSL);
      evs[ht] = !(vt >= VSS && vt < VSS + VSL);
      ov[ht]  = video;
      oh[ht]  = hsync;
      ovs[ht] = vsync;
      if (ht == HT - 1) begin
        check_line($sformatf("video f%0d l%0d", t / FRAME, vt), ov, ev);
        check_line($sformatf("hsync f%0d l%0d", t / FRAME, vt), oh, eh);
        check_line($sformatf("vsync f%0d l%0d", t / FRAME, vt), ovs, evs);
      end
      hn = cyc % HT;
      vn = (cyc / HT) % VT;
      if (col_arm && (cyc / FRAME) == col_frame && hn == 30 && vn == 2) begin
        bits_ready = 1'b1;
        bits = col_data; xaddr = 12'd32; yaddr = 12'd2;
        col_bank  = mdl_wr;
        col_arm   = 1'b0;
        col_apply = 1'b1;
      end else if (vn >= H && vn < VT - 1 && wq.size() > 0 && !gap) begin
        do_op(wq.pop_front());
        gap = 1'b1;
      end else begin
        gap = 1'b0;
      end
      if (hn == HT - 1 && vn == VT - 1) begin
        if (col_apply) fb[col_bank][2][2] = col_data;
        col_apply = 1'b0;
`ifdef MONO_DOUBLE_BUFFER_EN
        if (pend) begin
          mdl_rd = 1 - mdl_wr;
          pend = 1'b0;
        end
`endif
      end
    end
  endtask

  task automatic reset_pulse(input string tag);
    reset_n = 1'b0;
    bits_ready = 1'b1; bits = 16'hFFFF; xaddr = '0; yaddr = '0;
    #1;
    check_bit({tag, " video"}, video, INV);
    check_bit({tag, " hsync"}, hsync, 1'b1);
    check_bit({tag, " vsync"}, vsync, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit({tag, " video held"}, video, INV);
    bits_ready = 1'b0;
    reset_n = 1'b1;
    cyc = 0; mdl_wr = 0; mdl_rd = 0; pend = 1'b0; gap = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    mdl_wr = 0; mdl_rd = 0; pend = 1'b0; gap = 1'b0;
    col_arm = 1'b0; col_apply = 1'b0; col_frame = 0; col_bank = 0; col_data = '0;
    bits = '0; xaddr = '0; yaddr = '0; bits_ready = 1'b0; in_vsync = 1'b0; reset_n = 1'b1;
    for (int b = 0; b < 2; b++)
      for (int y = 0; y < int'(H); y++)
        for (int x = 0; x < int'(WD); x++) fb[b][y][x] = '0;
    @(negedge clk);
    reset_pulse("reset");

    // Frame 0: blank screen; writes land in its vertical blanking
    push_wr(16'h8001, 12'd0, 12'd0);
    push_wr(16'hFFFF, 12'hFF0, 12'd0);
    push_wr(16'hFFFF, 12'd0, 12'(H));
    push_wr(16'hFFFF, 12'hFF0, 12'd5);
    push_wr(16'hC3A5, 12'(W - 16), 12'(H - 1));
    for (int i = 0; i < 12; i++) begin
      logic [11:0] x, y;
      x = {4'($urandom_range(0, WD - 1)), 4'($urandom)};
      y = 12'($urandom_range(1, H - 1));
      if (i % 4 == 3) x = 12'hFF0 - 12'(16 * $urandom_range(0, 3));
      if (i % 5 == 4) y = 12'(H + $urandom_range(0, 20));
      push_wr(16'($urandom), x, y);
    end
    run_cycles(FRAME);
    run_cycles(FRAME);

    // Frame 2: rewrite the word being prefetched in the same cycle as its read
    col_data  = ~fb[mdl_wr][2][2];
    col_frame = 2;
    col_arm   = 1'b1;
    run_cycles(FRAME);

    // Frames 3..7: frame A completes, B is written in two halves, then B completes
    push_vs();
    run_cycles(FRAME);
    for (int y = 0; y < int'(H) / 2; y++)
      for (int x = 0; x < int'(WD); x++) push_wr(16'($urandom), 12'(16 * x), 12'(y));
    run_cycles(FRAME);
    for (int y = int'(H) / 2; y < int'(H); y++)
      for (int x = 0; x < int'(WD); x++) push_wr(16'($urandom), 12'(16 * x), 12'(y));
    push_vs();
    run_cycles(FRAME);
    run_cycles(FRAME);
    run_cycles(FRAME);

    // Reset in the middle of a frame, then two clean frames
    run_cycles(500);
    reset_pulse("midreset");
    run_cycles(2 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
